// File: rtl/score_disp_pkg.sv
// Shared constants for the score display: active-low segment patterns
// ({g,f,e,d,c,b,a}) and the digit slot order of the 4-digit scan.
package score_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Slot 0 is the rightmost digit; slots 2/3 carry the high score.
  typedef enum logic [1:0] {
    DIG_SL = 2'd0,
    DIG_SH = 2'd1,
    DIG_HL = 2'd2,
    DIG_HH = 2'd3
  } dig_e;

  // High score forced on game over after the counter has overflowed.
  localparam logic [7:0] HI_MAX = 8'h99;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder; non-decimal
// codes render as a dash.
module bcd_to_seg7
  import score_disp_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Score display stage: captures the BCD score, tracks overflow and the
// session high score, and scans both onto a 4-digit common-anode display.
module score_display
  import score_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 250
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLR,
  input  logic [3:0] SCORE_L,
  input  logic [3:0] SCORE_H,
  input  logic       SCORE_CA,
  input  logic       GAME_OVER,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       NEW_HI
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [3:0]    s_l_reg, s_h_reg;
  logic          s_ca_reg;
  logic          ovf_reg, ovf_next;
  logic [3:0]    hi_l_reg, hi_l_next, hi_h_reg, hi_h_next;
  logic          new_hi_reg, new_hi_next;
  logic [SW-1:0] scan_cnt_reg, scan_cnt_next;
  dig_e          dig_reg, dig_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          phase_on_reg, phase_on_next;
  logic [3:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;

  logic          tick, hi_set, show;
  logic [3:0]    digit_val;
  logic [6:0]    digit_seg;

  always_comb begin
    tick           = (scan_cnt_reg == SCAN_LAST);
    scan_cnt_next  = tick ? '0 : scan_cnt_reg + 1'b1;
    dig_next       = tick ? dig_e'(dig_reg + 2'd1) : dig_reg;

    // Compare uses the registered overflow, so a simultaneous CLR still
    // lets an overflowed game claim the maximum high score.
    hi_set         = GAME_OVER && (ovf_reg || ({s_h_reg, s_l_reg} > {hi_h_reg, hi_l_reg}));
    hi_l_next      = hi_l_reg;
    hi_h_next      = hi_h_reg;
    if (hi_set) begin
      if (ovf_reg) {hi_h_next, hi_l_next} = HI_MAX;
      else         {hi_h_next, hi_l_next} = {s_h_reg, s_l_reg};
    end

    new_hi_next    = new_hi_reg;
    if (hi_set)   new_hi_next = 1'b1;
    else if (CLR) new_hi_next = 1'b0;

    ovf_next       = CLR ? 1'b0 : (ovf_reg | s_ca_reg);

    blink_cnt_next = blink_cnt_reg;
    phase_on_next  = phase_on_reg;
    if (hi_set || !new_hi_next) begin
      blink_cnt_next = '0;
      phase_on_next  = 1'b1;
    end else if (tick) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next = '0;
        phase_on_next  = ~phase_on_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
      end
    end
  end

  // Digit mux: choose value and visibility for the slot currently scanned.
  always_comb begin
    digit_val = s_l_reg;
    show      = 1'b1;
    case (dig_reg)
      DIG_SL: begin digit_val = s_l_reg;  show = 1'b1;                                end
      DIG_SH: begin digit_val = s_h_reg;  show = (s_h_reg != 4'd0) || ovf_reg;       end
      DIG_HL: begin digit_val = hi_l_reg; show = phase_on_reg;                       end
      DIG_HH: begin digit_val = hi_h_reg; show = (hi_h_reg != 4'd0) && phase_on_reg; end
      default: begin digit_val = s_l_reg; show = 1'b1;                               end
    endcase
    seg_next = show ? digit_seg : SEG_BLANK;
    dp_next  = ~((dig_reg == DIG_SH) && ovf_reg);
  end

  bcd_to_seg7 u_dec (
    .value (digit_val),
    .seg   (digit_seg)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_an
      assign an_next[gi] = ~(show && (dig_reg == 2'(gi)));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_l_reg       <= '0;
      s_h_reg       <= '0;
      s_ca_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      hi_l_reg      <= '0;
      hi_h_reg      <= '0;
      new_hi_reg    <= 1'b0;
      scan_cnt_reg  <= '0;
      dig_reg       <= DIG_SL;
      blink_cnt_reg <= '0;
      phase_on_reg  <= 1'b1;
      an_reg        <= 4'b1111;
      seg_reg       <= SEG_BLANK;
      dp_reg        <= 1'b1;
    end else begin
      s_l_reg       <= SCORE_L;
      s_h_reg       <= SCORE_H;
      s_ca_reg      <= SCORE_CA;
      ovf_reg       <= ovf_next;
      hi_l_reg      <= hi_l_next;
      hi_h_reg      <= hi_h_next;
      new_hi_reg    <= new_hi_next;
      scan_cnt_reg  <= scan_cnt_next;
      dig_reg       <= dig_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_on_reg  <= phase_on_next;
      an_reg        <= an_next;
      seg_reg       <= seg_next;
      dp_reg        <= dp_next;
    end
  end

  assign AN     = an_reg;
  assign SEG    = seg_reg;
  assign DP     = dp_reg;
  assign NEW_HI = new_hi_reg;

endmodule

// File: doc/score_display.md
# score_display

Display stage downstream of the two-digit BCD score counter. It takes the counter's low digit, high digit and carry and keeps a session high score, updated on game over. It time-multiplexes current score and high score onto a 4-digit common-anode 7-segment display, with leading-zero blanking, an overflow marker and a blinking new-high-score indication.

## Interface
- SCAN_DIV, 50000: CLK cycles per digit slot; must be ≥ 2.
- BLINK_DIV, 250: scan ticks per blink half-period; must be ≥ 1.
- CLK  in  1  single clock; all state on rising edge.
- RESET  in  1  synchronous, active-high; clears all state including high score.
- CLR  in  1  new-game clear: clears overflow flag and NEW_HI; high score kept.
- SCORE_L  in  4  BCD low digit from score counter.
- SCORE_H  in  4  BCD high digit from score counter.
- SCORE_CA  in  1  counter carry (score at 99 and counting).
- GAME_OVER  in  1  single-cycle pulse; triggers high-score compare.
- AN  out  4  digit enables, active-low, bit i = digit i (0 = rightmost).
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low.
- NEW_HI  out  1  high, active-level: last game over set a new high score.

## Operation
- Input capture: SCORE_L/H/CA registered every cycle into s_l, s_h, s_ca. All decisions use the registered copies.
- Overflow flag ovf:
  - Set when s_ca = 1.
  - Cleared by CLR or RESET.
- High score hi_h:hi_l resets to 0:0.
- On GAME_OVER:
  - If ovf = 1: hi := 9:9 and NEW_HI := 1.
  - Else if {s_h,s_l} > {hi_h,hi_l}, as an 8-bit unsigned compare (valid for BCD): hi := score and NEW_HI := 1.
  - Equal or lower: no change.
- Simultaneous GAME_OVER and CLR: compare uses pre-clear ovf; hi update and NEW_HI set both take effect; ovf is cleared. Without GAME_OVER, CLR clears NEW_HI.
- Scan divider:
  - Counter 0..SCAN_DIV-1; tick when it reaches SCAN_DIV-1, then it wraps to 0.
  - Each tick advances digit index 0→1→2→3→0.
- Digit map and blanking:
  - 0 = s_l, always shown.
  - 1 = s_h, blanked when s_h = 0.
  - 2 = hi_l, always shown.
  - 3 = hi_h, blanked when hi_h = 0.
  - Blanked digit: AN bit stays inactive.
- Decode: values 0–9 use standard patterns. Values 10–15 show dash (segment g only).
- DP is lit only on digit 1 while ovf = 1. Digit 1 is not blanked while ovf = 1.
- Blink:
  - While NEW_HI = 1, phase toggles every BLINK_DIV scan ticks.
  - During the off phase, digits 2 and 3 are blanked.
  - Phase resets to on when NEW_HI sets.
  - NEW_HI = 0: phase held on.

## Timing
- Reset values:
  - AN = 4'b1111, SEG = 7'h7F, DP = 1.
  - NEW_HI = 0, ovf = 0, hi = 0:0.
  - Scan counter 0, digit index 0, blink phase on.
- AN/SEG/DP are registered. They reflect the new digit index 1 cycle after the tick edge. AN, SEG and DP change on the same edge, with no glitch between them.
- Score latency:
  - Input change → s_* after 1 cycle.
  - Visible when that digit is next scanned, +1 cycle output register.
  - Worst case 4·SCAN_DIV + 2 cycles.
- GAME_OVER at edge n:
  - hi and NEW_HI update at edge n+1.
  - Displayed on the next scan of digit 2/3.
- RESET mid-scan: all outputs reach reset values at the next edge; the scan restarts at digit 0.
- RESET overrides CLR and GAME_OVER in the same cycle.

## Structure
- Shared package score_disp_pkg:
  - SEG_* constants: patterns for 0–9, SEG_DASH, SEG_BLANK (active-low).
  - Digit index constants: DIG_SL, DIG_SH, DIG_HL, DIG_HH.
- Sub-module bcd_to_seg7: combinational 4-bit → 7-bit decoder, dash for >9. Instantiated once on the muxed digit value.
- Everything else lives in score_display: capture, ovf, high score, scan and blink counters, output registers.

## Test plan
All scenarios use SCAN_DIV = 4 and BLINK_DIV = 2.
- Reset then idle, SCORE = 0:0: AN cycles 1110 → (digit 1 blanked, AN 1111) → 1011 → 1111. SEG = 7'h40 ("0") on digits 0 and 2. NEW_HI = 0.
- SCORE = 4:7, pulse GAME_OVER:
  - NEW_HI = 1 the next cycle.
  - Digits 2/3 show "7", "4", blanking every 2 scan ticks.
  - Then apply CLR: NEW_HI = 0, steady display.
- Score 3:0 with hi = 4:7, then GAME_OVER: hi unchanged, NEW_HI stays 0. Repeat with score 4:7 (equal): unchanged.
- SCORE_CA = 1 for one cycle, then score 0:0:
  - DP = 0 and digit 1 shows "0" during digit-1 slots.
  - GAME_OVER sets hi = 9:9 and NEW_HI = 1.
  - CLR clears DP.
- GAME_OVER and CLR in the same cycle with score 6:0 > hi: hi = 6:0, NEW_HI = 1, ovf = 0.
- SCORE_L = 4'hC: digit 0 shows 7'h3F (dash). RESET asserted mid-scan: next edge AN = 1111, hi = 0:0.
